nn_result_uart_tx: RTL

NN_RESULT_UART_TX -- requirements
Module: nn_result_uart_tx

---
 rtl/nn_tx_pkg.sv | 33 +++
 rtl/uart_byte_tx.sv | 52 +++++
 rtl/nn_result_uart_tx.sv | 91 +++++++++
 3 files changed

// File: rtl/nn_tx_pkg.sv
// nn_tx_pkg: shared types, constants and frame-byte helper for nn_result_uart_tx
//   SYNC_BYTE, FRAME_LEN_BASE/FRAME_LEN_CSUM, FRAME_LEN (active length),
//   seq_state_e (frame sequencer states), result_pair_t ({x, y} as 16-bit words),
//   frame_byte() maps a byte index to the wire byte of a result pair.
//   NN_TX_CHECKSUM_EN: when defined, frames carry a sixth XOR checksum byte.
package nn_tx_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN_BASE = 5;
  localparam int FRAME_LEN_CSUM = 6;
`ifdef NN_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int FRAME_LEN = CSUM_EN ? FRAME_LEN_CSUM : FRAME_LEN_BASE;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_NEXT} seq_state_e;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } result_pair_t;
  function automatic logic [7:0] frame_byte(input result_pair_t p, input logic [2:0] idx);
    logic [7:0] b;
    b = idx == 3'd1 ? p.x[15:8] :
        idx == 3'd2 ? p.x[7:0]  :
        idx == 3'd3 ? p.y[15:8] :
        idx == 3'd4 ? p.y[7:0]  : SYNC_BYTE;
`ifdef NN_TX_CHECKSUM_EN
    // checksum covers the payload only, not the sync byte
    if (idx == 3'd5) b = p.x[15:8] ^ p.x[7:0] ^ p.y[15:8] ^ p.y[7:0];
`endif
    return b;
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serializer, LSB first, one registered output bit
//   clk_i/rst_i  clock, synchronous active-high reset
//   start_i      load data_i; accepted when idle or in the last cycle of a stop bit
//   data_i       byte to send
//   done_o       high in the last cycle of the stop bit
//   busy_o       a byte is being shifted
//   tx_o         serial line, idle high
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       busy_o,
  output logic       tx_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d, tx_q, tx_d, bit_end, load;
  always_comb begin
    bit_end = baud_q == CW'(CLKS_PER_BIT - 1);
    done_o  = busy_q && bit_end && bit_q == 4'd9;
    // accepting start during done chains the next start bit with no idle time
    load    = start_i && (!busy_q || done_o);
    busy_d  = load || (busy_q && !done_o);
    baud_d  = (load || !busy_q || bit_end) ? '0 : baud_q + 1'b1;
    bit_d   = (load || done_o || !busy_q) ? '0 : bit_end ? bit_q + 1'b1 : bit_q;
    shift_d = load ? {1'b1, data_i, 1'b0} : (busy_q && bit_end) ? {1'b1, shift_q[9:1]} : shift_q;
    tx_d    = busy_q ? shift_q[0] : 1'b1;
    busy_o  = busy_q;
    tx_o    = tx_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: rtl/nn_result_uart_tx.sv
// nn_result_uart_tx: buffers {x, y} inference results and streams them as UART frames
//   clk_i/rst_i   clock, synchronous active-high reset
//   valid_i       one-cycle result strobe; x_i/y_i sampled with it (signed, WIDTH bits)
//   uart_tx_o     8N1 line: A5, x hi, x lo, y hi, y lo [, XOR checksum]
//   busy_o        frame in progress or results pending
//   drop_o        pulse the cycle after a result is lost to a full buffer
//   drop_cnt_o    saturating lost-result count
//   NN_TX_CHECKSUM_EN: when defined, a sixth checksum byte is appended.
module nn_result_uart_tx import nn_tx_pkg::*; #(
  parameter int WIDTH      = 16,
  parameter int CLK_HZ     = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic             drop_o,
  output logic [7:0]       drop_cnt_o
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  seq_state_e   state_q, state_d;
  result_pair_t mem_q [FIFO_DEPTH];
  result_pair_t pair_q, pair_d, in_pair;
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   cnt_q, cnt_d, tx_data;
  logic         drop_q, drop_d, empty, full, push, pop, tx_start, tx_done, tx_busy;
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(tx_start),
    .data_i (tx_data),
    .done_o (tx_done),
    .busy_o (tx_busy),
    .tx_o   (uart_tx_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      pair_q  <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pair_q  <= pair_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= in_pair;
  end
  // idx_q already points past the byte that just finished when NEXT is reached
  always_comb begin
    state_d = state_q == S_IDLE ? (empty ? S_IDLE : S_LOAD) :
              state_q == S_LOAD ? S_SEND :
              state_q == S_SEND ? (tx_done ? S_NEXT : S_SEND) :
              (idx_q < 3'(FRAME_LEN) ? S_SEND : S_IDLE);
  end
  always_comb begin
    in_pair    = {16'($signed(x_i)), 16'($signed(y_i))};
    empty      = wr_q == rd_q;
    full       = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    push       = valid_i && !full;
    pop        = state_q == S_IDLE && !empty;
    wr_d       = wr_q + (AW+1)'(push);
    rd_d       = rd_q + (AW+1)'(pop);
    pair_d     = pop ? mem_q[rd_q[AW-1:0]] : pair_q;
    // the next byte is handed over during the current stop bit's last cycle
    tx_start   = state_q == S_LOAD || (state_q == S_SEND && tx_done && idx_q != 3'(FRAME_LEN - 1));
    tx_data    = frame_byte(pair_q, state_q == S_LOAD ? 3'd0 : idx_q + 3'd1);
    idx_d      = state_q == S_LOAD ? '0 : (state_q == S_SEND && tx_done) ? idx_q + 3'd1 : idx_q;
    drop_d     = valid_i && full;
    cnt_d      = cnt_q + 8'(drop_d && cnt_q != 8'hFF);
    busy_o     = state_q != S_IDLE || !empty || tx_busy;
    drop_o     = drop_q;
    drop_cnt_o = cnt_q;
  end
endmodule
